// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage RV32I pipeline.
// Produces E-stage operand forwarding selects, per-stage stall/flush
// controls, a memory-wait timeout watchdog and saturating stall counters.
module hazard_ctrl #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       Rs1D,
    input  logic [4:0]       Rs2D,
    input  logic [4:0]       Rs1E,
    input  logic [4:0]       Rs2E,
    input  logic [4:0]       RdE,
    input  logic [4:0]       RdM,
    input  logic [4:0]       RdW,
    input  logic             ResultSrcE0,
    input  logic             RegWriteM,
    input  logic             RegWriteW,
    input  logic             PCSrcE,
    input  logic             MemReqM,
    input  logic             MemReadyM,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             StallM,
    output logic             StallW,
    output logic             FlushD,
    output logic             FlushE,
    output logic             MemTimeout,
    output logic [CNT_W-1:0] LoadStallCnt,
    output logic [CNT_W-1:0] MemStallCnt
);

    // Wait counter only needs to reach TIMEOUT-1 before the watchdog fires.
    localparam int WAIT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERROR    = 2'd2
    } state_t;

    state_t              state_reg;
    logic [WAIT_W-1:0]   wait_cnt_reg;
    logic [CNT_W-1:0]    load_cnt_reg;
    logic [CNT_W-1:0]    mem_cnt_reg;

    logic                lw_stall;
    logic                mem_stall;
    logic                freeze;
    logic                lw_row;

    logic [4:0]          rs_e [2];
    logic [1:0]          fwd  [2];

    assign rs_e[0] = Rs1E;
    assign rs_e[1] = Rs2E;

    // Forwarding selects: M-stage result beats W-stage result; x0 never forwards.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
            assign fwd[gi] = (RegWriteM && (RdM != 5'd0) && (rs_e[gi] == RdM)) ? 2'b10 :
                             (RegWriteW && (RdW != 5'd0) && (rs_e[gi] == RdW)) ? 2'b01 :
                                                                                 2'b00;
        end
    endgenerate

    assign ForwardAE = fwd[0];
    assign ForwardBE = fwd[1];

    assign lw_stall  = ResultSrcE0 && (RdE != 5'd0) && ((Rs1D == RdE) || (Rs2D == RdE));
    assign mem_stall = ((state_reg == RUN) && MemReqM && !MemReadyM) ||
                       ((state_reg == MEM_WAIT) && !MemReadyM);
    assign freeze    = (state_reg == ERROR) || mem_stall;

    // The load-use row only wins when nothing of higher priority is active.
    assign lw_row    = !rst && !freeze && !PCSrcE && lw_stall;

    // Stall/flush priority: reset, frozen pipe, taken branch, load-use, idle.
    always_comb begin
        StallF = 1'b0;
        StallD = 1'b0;
        StallE = 1'b0;
        StallM = 1'b0;
        StallW = 1'b0;
        FlushD = 1'b0;
        FlushE = 1'b0;
        if (rst) begin
            FlushD = 1'b1;
            FlushE = 1'b1;
        end else if (freeze) begin
            StallF = 1'b1;
            StallD = 1'b1;
            StallE = 1'b1;
            StallM = 1'b1;
            StallW = 1'b1;
        end else if (PCSrcE) begin
            FlushD = 1'b1;
            FlushE = 1'b1;
        end else if (lw_stall) begin
            StallF = 1'b1;
            StallD = 1'b1;
            FlushE = 1'b1;
        end
    end

    // Memory-wait sequencer with timeout watchdog; ERROR holds until reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= RUN;
            wait_cnt_reg <= '0;
        end else begin
            case (state_reg)
                RUN: begin
                    if (MemReqM && !MemReadyM) begin
                        state_reg    <= MEM_WAIT;
                        wait_cnt_reg <= WAIT_W'(1);
                    end else begin
                        wait_cnt_reg <= '0;
                    end
                end
                MEM_WAIT: begin
                    if (MemReadyM) begin
                        state_reg    <= RUN;
                        wait_cnt_reg <= '0;
                    end else if (wait_cnt_reg == WAIT_W'(TIMEOUT - 1)) begin
                        state_reg    <= ERROR;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg + WAIT_W'(1);
                    end
                end
                ERROR: begin
                    state_reg <= ERROR;
                end
                default: begin
                    state_reg    <= RUN;
                    wait_cnt_reg <= '0;
                end
            endcase
        end
    end

    // Saturating performance counters for cycles lost to each stall cause.
    always_ff @(posedge clk) begin
        if (rst) begin
            load_cnt_reg <= '0;
            mem_cnt_reg  <= '0;
        end else begin
            if (lw_row && (load_cnt_reg != '1)) begin
                load_cnt_reg <= load_cnt_reg + CNT_W'(1);
            end
            if (mem_stall && (mem_cnt_reg != '1)) begin
                mem_cnt_reg <= mem_cnt_reg + CNT_W'(1);
            end
        end
    end

    assign MemTimeout   = (state_reg == ERROR);
    assign LoadStallCnt = load_cnt_reg;
    assign MemStallCnt  = mem_cnt_reg;

endmodule
